// File: rtl/tc_result_wb_if.sv
// rtl/tc_result_wb_if.sv - tile input and row writeback signals for tc_result_wb
interface tc_result_wb_if #(
   parameter int SHAPE_M    = 8,
   parameter int SHAPE_K    = 8,
   parameter int ELEM_WIDTH = 8,
   parameter int DEPTH_WARP = 4
) ();
   logic                                  in_valid_i;
   logic                                  in_ready_o;
   logic [SHAPE_M*SHAPE_K*ELEM_WIDTH-1:0] result_i;
   logic [4:0]                            fflags_i;
   logic [7:0]                            reg_idxw_i;
   logic [DEPTH_WARP-1:0]                 warpid_i;
   logic [SHAPE_M-1:0]                    row_mask_i;
   logic                                  wb_valid_o;
   logic                                  wb_ready_i;
   logic [SHAPE_K*ELEM_WIDTH-1:0]         wb_data_o;
   logic [7:0]                            wb_reg_idx_o;
   logic [DEPTH_WARP-1:0]                 wb_warpid_o;
   logic                                  wb_last_o;
   logic [4:0]                            wb_fflags_o;
   logic                                  busy_o;

   modport slave (
      input  in_valid_i, result_i, fflags_i, reg_idxw_i, warpid_i, row_mask_i, wb_ready_i,
      output in_ready_o, wb_valid_o, wb_data_o, wb_reg_idx_o, wb_warpid_o, wb_last_o,
             wb_fflags_o, busy_o
   );

   modport master (
      output in_valid_i, result_i, fflags_i, reg_idxw_i, warpid_i, row_mask_i, wb_ready_i,
      input  in_ready_o, wb_valid_o, wb_data_o, wb_reg_idx_o, wb_warpid_o, wb_last_o,
             wb_fflags_o, busy_o
   );
endinterface

// File: rtl/tc_result_wb.sv
// rtl/tc_result_wb.sv - drains a masked result tile as one register-file beat per selected row
module tc_result_wb #(
   parameter int SHAPE_M    = 8,
   parameter int SHAPE_K    = 8,
   parameter int ELEM_WIDTH = 8,
   parameter int DEPTH_WARP = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   tc_result_wb_if.slave bus
);
   localparam int ROW_BITS  = SHAPE_K * ELEM_WIDTH;
   localparam int TILE_BITS = SHAPE_M * ROW_BITS;
   localparam int ROW_W     = (SHAPE_M > 1) ? $clog2(SHAPE_M) : 1;

   typedef enum logic {IDLE, DRAIN} state_t;

   state_t                r_state;
   logic [TILE_BITS-1:0]  r_tile;
   logic [SHAPE_M-1:0]    r_mask;
   logic [7:0]            r_base;
   logic [4:0]            r_flags;
   logic                  r_in_ready;
   logic                  r_busy;
   logic                  r_wb_valid;
   logic [ROW_BITS-1:0]   r_wb_data;
   logic [7:0]            r_wb_idx;
   logic [DEPTH_WARP-1:0] r_wb_warpid;
   logic                  r_wb_last;
   logic [4:0]            r_wb_fflags;

   logic [SHAPE_M-1:0]    w_src_mask;
   logic [TILE_BITS-1:0]  w_src_tile;
   logic [7:0]            w_src_base;
   logic [4:0]            w_src_flags;
   logic [ROW_W-1:0]      w_row;
   logic [SHAPE_M-1:0]    w_rest;
   logic                  w_last;
   logic [ROW_BITS-1:0]   w_row_data;
   logic [7:0]            w_idx;
   logic [4:0]            w_fflags;

   function automatic logic [ROW_W-1:0] f_lowest(input logic [SHAPE_M-1:0] m);
      logic [ROW_W-1:0] r;
      r = '0;
      for (int i = SHAPE_M - 1; i >= 0; i--) begin
         if (m[i]) r = ROW_W'(i);
      end
      return r;
   endfunction

   // In IDLE the beat is built straight from the inputs so the first row appears one cycle after capture.
   assign w_src_mask  = (r_state == IDLE) ? bus.row_mask_i : r_mask;
   assign w_src_tile  = (r_state == IDLE) ? bus.result_i   : r_tile;
   assign w_src_base  = (r_state == IDLE) ? bus.reg_idxw_i : r_base;
   assign w_src_flags = (r_state == IDLE) ? bus.fflags_i   : r_flags;

   assign w_row      = f_lowest(w_src_mask);
   assign w_rest     = w_src_mask & ~(SHAPE_M'(1) << w_row);
   assign w_last     = (w_rest == '0);
   assign w_row_data = w_src_tile[w_row*ROW_BITS +: ROW_BITS];
   assign w_idx      = w_src_base + 8'(w_row);
   assign w_fflags   = w_last ? w_src_flags : 5'd0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_tile      <= '0;
         r_mask      <= '0;
         r_base      <= '0;
         r_flags     <= '0;
         r_in_ready  <= 1'b1;
         r_busy      <= 1'b0;
         r_wb_valid  <= 1'b0;
         r_wb_data   <= '0;
         r_wb_idx    <= '0;
         r_wb_warpid <= '0;
         r_wb_last   <= 1'b0;
         r_wb_fflags <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               // A zero-mask tile is consumed and dropped without leaving IDLE.
               if (bus.in_valid_i && r_in_ready && (bus.row_mask_i != '0)) begin
                  r_tile      <= bus.result_i;
                  r_base      <= bus.reg_idxw_i;
                  r_flags     <= bus.fflags_i;
                  r_mask      <= w_rest;
                  r_wb_valid  <= 1'b1;
                  r_wb_data   <= w_row_data;
                  r_wb_idx    <= w_idx;
                  r_wb_warpid <= bus.warpid_i;
                  r_wb_last   <= w_last;
                  r_wb_fflags <= w_fflags;
                  r_in_ready  <= 1'b0;
                  r_busy      <= 1'b1;
                  r_state     <= DRAIN;
               end
            end
            DRAIN: begin
               if (bus.wb_ready_i) begin
                  if (r_wb_last) begin
                     r_wb_valid  <= 1'b0;
                     r_wb_last   <= 1'b0;
                     r_wb_fflags <= '0;
                     r_in_ready  <= 1'b1;
                     r_busy      <= 1'b0;
                     r_state     <= IDLE;
                  end else begin
                     r_mask      <= w_rest;
                     r_wb_data   <= w_row_data;
                     r_wb_idx    <= w_idx;
                     r_wb_last   <= w_last;
                     r_wb_fflags <= w_fflags;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready_o   = r_in_ready;
   assign bus.busy_o       = r_busy;
   assign bus.wb_valid_o   = r_wb_valid;
   assign bus.wb_data_o    = r_wb_data;
   assign bus.wb_reg_idx_o = r_wb_idx;
   assign bus.wb_warpid_o  = r_wb_warpid;
   assign bus.wb_last_o    = r_wb_last;
   assign bus.wb_fflags_o  = r_wb_fflags;
endmodule

// File: tb/tb_tc_result_wb.sv
// tb/tb_tc_result_wb.sv - scoreboard bench for tc_result_wb with directed tiles
module tb_tc_result_wb;
   logic clk;
   logic rst_n;

   tc_result_wb_if #(.SHAPE_M(8), .SHAPE_K(8), .ELEM_WIDTH(8), .DEPTH_WARP(4)) bus ();

   tc_result_wb #(.SHAPE_M(8), .SHAPE_K(8), .ELEM_WIDTH(8), .DEPTH_WARP(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  idx;
      logic [3:0]  warp;
      logic        last;
      logic [4:0]  ff;
   } beat_t;

   beat_t exp_q[$];
   beat_t prev_beat;
   logic  stalled_prev;
   int    checks;
   int    errors;
   int    stall_cycles;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [511:0] mk_tile(input logic [7:0] seed);
      logic [511:0] t;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            t[(r*8+c)*8 +: 8] = seed + 8'(r);
      return t;
   endfunction

   task automatic push_exp(input logic [7:0] byte_v, input logic [7:0] idx, input logic [3:0] warp,
                           input logic last, input logic [4:0] ff);
      beat_t b;
      b.data = {8{byte_v}};
      b.idx  = idx;
      b.warp = warp;
      b.last = last;
      b.ff   = ff;
      exp_q.push_back(b);
   endtask

   // Monitor: pops the scoreboard on every accepted beat and checks that stalled beats hold.
   always @(negedge clk) begin
      beat_t cur;
      cur = {bus.wb_data_o, bus.wb_reg_idx_o, bus.wb_warpid_o, bus.wb_last_o, bus.wb_fflags_o};
      if (rst_n && bus.wb_valid_o) begin
         if (stalled_prev) chk("stall_hold", 64'(cur), 64'(prev_beat));
         if (bus.wb_ready_i) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat_idx", 64'(bus.wb_reg_idx_o), 64'hFFFF);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               chk("beat_data", cur.data, e.data);
               chk("beat_idx", 64'(cur.idx), 64'(e.idx));
               chk("beat_warp", 64'(cur.warp), 64'(e.warp));
               chk("beat_last", 64'(cur.last), 64'(e.last));
               chk("beat_fflags", 64'(cur.ff), 64'(e.ff));
            end
            stalled_prev = 1'b0;
         end else begin
            stalled_prev = 1'b1;
            prev_beat    = cur;
            stall_cycles++;
         end
      end else begin
         stalled_prev = 1'b0;
      end
   end

   task automatic drive_tile(input logic [7:0] seed, input logic [4:0] ff, input logic [7:0] base,
                             input logic [3:0] warp, input logic [7:0] mask);
      bus.result_i   = mk_tile(seed);
      bus.fflags_i   = ff;
      bus.reg_idxw_i = base;
      bus.warpid_i   = warp;
      bus.row_mask_i = mask;
      bus.in_valid_i = 1'b1;
   endtask

   task automatic send_tile(input logic [7:0] seed, input logic [4:0] ff, input logic [7:0] base,
                            input logic [3:0] warp, input logic [7:0] mask);
      drive_tile(seed, ff, base, warp, mask);
      @(posedge clk);
      #1;
      bus.in_valid_i = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (!(exp_q.size() == 0 && bus.in_ready_o) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_drained"}, 64'(exp_q.size() == 0 && bus.in_ready_o), 64'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int k;
      int seen;
      checks        = 0;
      errors        = 0;
      stall_cycles  = 0;
      stalled_prev  = 1'b0;
      prev_beat     = '0;
      rst_n         = 1'b0;
      bus.in_valid_i = 1'b0;
      bus.wb_ready_i = 1'b1;
      bus.result_i   = '0;
      bus.fflags_i   = '0;
      bus.reg_idxw_i = '0;
      bus.warpid_i   = '0;
      bus.row_mask_i = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
      chk("rst_wb_valid", 64'(bus.wb_valid_o), 64'd0);
      chk("rst_busy", 64'(bus.busy_o), 64'd0);
      chk("rst_wb_last", 64'(bus.wb_last_o), 64'd0);
      chk("rst_wb_data", bus.wb_data_o, 64'd0);
      chk("rst_wb_fields", 64'({bus.wb_reg_idx_o, bus.wb_warpid_o, bus.wb_fflags_o}), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Full tile: 8 beats, rows hold value r, base 0x10, 9 cycles including the capture cycle.
      for (int r = 0; r < 8; r++)
         push_exp(8'(r), 8'h10 + 8'(r), 4'h2, r == 7, (r == 7) ? 5'b10001 : 5'b0);
      send_tile(8'h00, 5'b10001, 8'h10, 4'h2, 8'hFF);
      chk("full_busy", 64'(bus.busy_o), 64'd1);
      chk("full_in_ready_low", 64'(bus.in_ready_o), 64'd0);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!bus.in_ready_o && k < 50);
      chk("full_cycles", 64'(k), 64'd9);
      chk("full_busy_clear", 64'(bus.busy_o), 64'd0);
      wait_idle("full");

      // Sparse mask 1000_0101: rows 0, 2, 7 with flags only on the last beat.
      push_exp(8'hA0, 8'h20, 4'h3, 1'b0, 5'b0);
      push_exp(8'hA2, 8'h22, 4'h3, 1'b0, 5'b0);
      push_exp(8'hA7, 8'h27, 4'h3, 1'b1, 5'b00101);
      send_tile(8'hA0, 5'b00101, 8'h20, 4'h3, 8'b1000_0101);
      wait_idle("sparse");

      // Backpressure on beat 2, with garbage on the input while draining.
      push_exp(8'h50, 8'h40, 4'h5, 1'b0, 5'b0);
      push_exp(8'h51, 8'h41, 4'h5, 1'b0, 5'b0);
      push_exp(8'h52, 8'h42, 4'h5, 1'b0, 5'b0);
      push_exp(8'h53, 8'h43, 4'h5, 1'b1, 5'b00010);
      send_tile(8'h50, 5'b00010, 8'h40, 4'h5, 8'h0F);
      drive_tile(8'hEE, 5'b11111, 8'hC0, 4'hF, 8'hFF);
      stall_cycles = 0;
      @(posedge clk);
      #1;
      bus.wb_ready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      bus.wb_ready_i = 1'b1;
      bus.in_valid_i = 1'b0;
      chk("bp_stall_cycles", 64'(stall_cycles), 64'd3);
      wait_idle("bp");

      // Register index wraps past 0xFF.
      push_exp(8'h30, 8'hFE, 4'h1, 1'b0, 5'b0);
      push_exp(8'h31, 8'hFF, 4'h1, 1'b0, 5'b0);
      push_exp(8'h32, 8'h00, 4'h1, 1'b0, 5'b0);
      push_exp(8'h33, 8'h01, 4'h1, 1'b1, 5'b01000);
      send_tile(8'h30, 5'b01000, 8'hFE, 4'h1, 8'h0F);
      wait_idle("wrap");

      // Zero mask is dropped and the next tile is taken on the following cycle.
      drive_tile(8'h70, 5'b11111, 8'h60, 4'h6, 8'h00);
      @(posedge clk);
      #1;
      chk("zero_wb_valid", 64'(bus.wb_valid_o), 64'd0);
      chk("zero_in_ready", 64'(bus.in_ready_o), 64'd1);
      push_exp(8'h80, 8'h50, 4'h7, 1'b0, 5'b0);
      push_exp(8'h81, 8'h51, 4'h7, 1'b1, 5'b00001);
      send_tile(8'h80, 5'b00001, 8'h50, 4'h7, 8'h03);
      chk("zero_next_valid", 64'(bus.wb_valid_o), 64'd1);
      chk("zero_next_in_ready", 64'(bus.in_ready_o), 64'd0);
      wait_idle("zero_next");

      // Reset after three of eight beats abandons the tile.
      for (int r = 0; r < 8; r++)
         push_exp(8'(r), 8'h10 + 8'(r), 4'h4, r == 7, (r == 7) ? 5'b00011 : 5'b0);
      send_tile(8'h00, 5'b00011, 8'h10, 4'h4, 8'hFF);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_mid_beats_left", 64'(exp_q.size()), 64'd5);
      chk("rst_mid_wb_valid", 64'(bus.wb_valid_o), 64'd0);
      chk("rst_mid_in_ready", 64'(bus.in_ready_o), 64'd1);
      chk("rst_mid_busy", 64'(bus.busy_o), 64'd0);
      exp_q.delete();
      rst_n = 1'b1;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.wb_valid_o) seen++;
      end
      chk("rst_mid_no_beats", 64'(seen), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
